sha256_round_ctrl: RTL

- Sequencing controller for the SHA-256 compression datapath.
- Accepts one 512-bit block per valid/ready handshake and selects IV or chained hash as the start state.
- Steps round_n 0..63 into the K-constant ROM (k_generator) and the message-schedule mux, then issues the hash-update strobe.
- For the last block of a message, holds digest_valid until the consumer accepts it. Instantiated beside k_generator in the hashing core top.

---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_round_ctrl_if.sv | 23 ++
 rtl/sha256_round_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-256 round controller: round counts, counter
// width and the binary encoding of the sequencing FSM.
package sha256_pkg;

    localparam int ROUNDS    = 64;  // compression rounds per block
    localparam int MSG_WORDS = 16;  // rounds that take W straight from the block
    localparam int CNT_W     = 6;   // width of the round index, 2**CNT_W >= ROUNDS

    typedef logic [CNT_W-1:0] round_t;

    // Sequencing FSM encoding, 3-bit binary.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_ROUND  = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Block-input and digest-output handshakes of the SHA-256 round controller.
// The master side is whoever feeds message blocks and consumes the digest;
// the slave side is the controller itself.
interface sha256_round_ctrl_if;

    logic blk_valid;     // a 512-bit block is presented
    logic blk_ready;     // controller can take a block
    logic first_blk;     // qualifies blk_valid: start from IV
    logic last_blk;      // qualifies blk_valid: final block of the message
    logic digest_valid;  // H holds the final digest
    logic digest_ready;  // consumer takes the digest

    modport master (
        output blk_valid, first_blk, last_blk, digest_ready,
        input  blk_ready, digest_valid
    );

    modport slave (
        input  blk_valid, first_blk, last_blk, digest_ready,
        output blk_ready, digest_valid
    );

endinterface

// File: rtl/sha256_round_ctrl.sv
// Sequencing controller for the SHA-256 compression datapath. Accepts one
// block per handshake, loads the working variables, steps the round index
// through 0..ROUNDS-1, issues the hash-update strobe and, for the last block
// of a message, holds digest_valid until the consumer takes it.
module sha256_round_ctrl
    import sha256_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    sha256_round_ctrl_if.slave  bus,
    input  logic                i_abort,
    output logic [CNT_W-1:0]    o_round_n,
    output logic                o_w_from_msg,
    output logic                o_msg_load,
    output logic                o_init_iv,
    output logic                o_load_wv,
    output logic                o_round_en,
    output logic                o_hash_upd,
    output logic                o_busy
);

    localparam round_t LAST_ROUND = round_t'(ROUNDS - 1);
    localparam round_t MSG_LIMIT  = round_t'(MSG_WORDS);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    round_t     r_round_n;
    round_t     w_round_nxt;
    logic       r_first_q;
    logic       r_last_q;
    logic       w_accept;

    // A block is taken only in IDLE; abort in the same cycle refuses it.
    assign w_accept = (r_state == ST_IDLE) && bus.blk_valid && !i_abort;

    // Next-state and round-counter decode; abort overrides every transition.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_state_nxt = r_state;
        w_round_nxt = r_round_n;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_round_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.blk_valid) w_state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    w_state_nxt = ST_ROUND;
                    w_round_nxt = '0;
                end
                ST_ROUND: begin
                    // Leave on the last round so the counter never wraps inside ROUND.
                    if (r_round_n == LAST_ROUND) begin
                        w_state_nxt = ST_UPDATE;
                        w_round_nxt = '0;
                    end else begin
                        w_round_nxt = r_round_n + 1'b1;
                    end
                end
                ST_UPDATE: begin
                    w_state_nxt = r_last_q ? ST_OUT : ST_IDLE;
                end
                ST_OUT: begin
                    if (bus.digest_ready) w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_round_nxt = '0;
                end
            endcase
        end
    end

    // State, round index and block qualifiers; reset drops straight to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_round_n <= '0;
            r_first_q <= 1'b0;
            r_last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state   <= w_state_nxt;
            r_round_n <= w_round_nxt;
            if (w_accept) begin
                r_first_q <= bus.first_blk;
                r_last_q  <= bus.last_blk;
            end
        end
    end

    // Strobes decoded from registered state; msg_load follows the handshake,
    // and an abort in UPDATE cancels the hash update of that same cycle.
    assign bus.blk_ready    = (r_state == ST_IDLE);
    assign bus.digest_valid = (r_state == ST_OUT);
    assign o_msg_load       = w_accept;
    assign o_load_wv        = (r_state == ST_LOAD);
    assign o_init_iv        = (r_state == ST_LOAD) && r_first_q;
    assign o_round_en       = (r_state == ST_ROUND);
    assign o_hash_upd       = (r_state == ST_UPDATE) && !i_abort;
    assign o_busy           = (r_state != ST_IDLE);
    assign o_round_n        = r_round_n;
    // Only meaningful while rounds run, so it is held low elsewhere.
    assign o_w_from_msg     = o_round_en && (r_round_n < MSG_LIMIT);

endmodule
